// File: rtl/alu_issue_stage.sv
// RV64I integer-computational decode/issue stage feeding the 64-bit ALU.
// Two-entry output queue (output register + skid register) keeps full throughput under backpressure.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_val_i,
  input  logic [DATA_WIDTH-1:0] rs2_val_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [3:0]            alu_op_o,
  output logic [4:0]            rd_o,
  output logic                  illegal_o
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR   = 4'd2,  OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_COPYB = 4'd10;
  localparam logic [3:0] OP_ADDW = 4'd11, OP_SUBW = 4'd12, OP_SLLW = 4'd13;
  localparam logic [3:0] OP_SRLW = 4'd14, OP_SRAW = 4'd15;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            op;
    logic [4:0]            rd;
    logic                  ill;
  } entry_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [DATA_WIDTH-1:0] i_imm, u_imm, shamt6, shamt5;
  logic                  f7_ok;
  logic                  legal;
  entry_t                dec;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign i_imm  = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign u_imm  = {{(DATA_WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign shamt6 = {{(DATA_WIDTH-6){1'b0}}, instr_i[25:20]};
  assign shamt5 = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
  // Register-register forms allow the alternate funct7 only for SUB and SRA variants.
  assign f7_ok  = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    dec     = '0;
    dec.rd  = instr_i[11:7];
    dec.op  = OP_ADD;
    legal   = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.a  = rs1_val_i;
        dec.b  = rs2_val_i;
        dec.op = base_op(f3, f7[5]);
        legal  = f7_ok;
      end
      7'b0010011: begin
        dec.a = rs1_val_i;
        if (f3 == 3'b001) begin
          dec.b  = shamt6;
          dec.op = OP_SLL;
          legal  = (instr_i[31:26] == 6'b000000);
        end else if (f3 == 3'b101) begin
          dec.b  = shamt6;
          dec.op = base_op(f3, instr_i[30]);
          legal  = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
        end else begin
          dec.b  = i_imm;
          dec.op = base_op(f3, 1'b0);
          legal  = 1'b1;
        end
      end
      7'b0111011: begin
        dec.a = rs1_val_i;
        dec.b = rs2_val_i;
        case (f3)
          3'b000: begin dec.op = f7[5] ? OP_SUBW : OP_ADDW; legal = f7_ok; end
          3'b001: begin dec.op = OP_SLLW; legal = (f7 == 7'b0000000); end
          3'b101: begin dec.op = f7[5] ? OP_SRAW : OP_SRLW; legal = f7_ok; end
          default: legal = 1'b0;
        endcase
      end
      7'b0011011: begin
        dec.a = rs1_val_i;
        case (f3)
          3'b000: begin dec.b = i_imm; dec.op = OP_ADDW; legal = 1'b1; end
          3'b001: begin dec.b = shamt5; dec.op = OP_SLLW; legal = (f7 == 7'b0000000); end
          3'b101: begin
            dec.b  = shamt5;
            dec.op = f7[5] ? OP_SRAW : OP_SRLW;
            legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0110111: begin dec.b = u_imm; dec.op = OP_COPYB; legal = 1'b1; end
      7'b0010111: begin dec.a = pc_i; dec.b = u_imm; dec.op = OP_ADD; legal = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.op  = OP_ADD;
      dec.ill = 1'b1;
    end
  end

  entry_t out_q, out_n, skid_q, skid_n;
  logic   out_v, out_v_n, skid_v, skid_v_n, rdy_q, rdy_n;
  logic   accept, slot_free;

  assign accept    = in_valid_i & rdy_q;
  assign slot_free = ~out_v | out_ready_i;

  always_comb begin
    out_n    = out_q;
    skid_n   = skid_q;
    out_v_n  = out_v;
    skid_v_n = skid_v;
    if (flush_i) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
    end else if (slot_free) begin
      if (skid_v) begin
        out_n    = skid_q;
        out_v_n  = 1'b1;
        skid_v_n = 1'b0;
      end else if (accept) begin
        out_n   = dec;
        out_v_n = 1'b1;
      end else begin
        out_v_n = 1'b0;
      end
    end else if (accept) begin
      skid_n   = dec;
      skid_v_n = 1'b1;
    end
    rdy_n = ~skid_v_n;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      out_q  <= out_n;
      skid_q <= skid_n;
      out_v  <= out_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= rdy_n;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = out_v;
  assign alu_a_o     = out_q.a;
  assign alu_b_o     = out_q.b;
  assign alu_op_o    = out_q.op;
  assign rd_o        = out_q.rd;
  assign illegal_o   = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: table-driven decode model plus a 2-deep queue model of the handshake,
// checked every cycle, with directed literal cases and randomized traffic.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0, rs1 = '0, rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .rs1_val_i(rs1), .rs2_val_i(rs2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .rd_o(rd), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  entry_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: funct3 -> base op table, alternate-funct7 forms are base+1.
  function automatic entry_t ref_decode(input logic [31:0] ins, input logic [63:0] p,
                                        input logic [63:0] r1, input logic [63:0] r2);
    entry_t e;
    int base [8] = '{0, 5, 8, 9, 4, 6, 2, 3};
    int wop;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic alt = ins[30];
    bit ok = 0;
    logic [63:0] iimm = {{52{ins[31]}}, ins[31:20]};
    logic [63:0] uimm = {{32{ins[31]}}, ins[31:12], 12'h000};
    e.a = 0; e.b = 0; e.op = 0; e.rd = ins[11:7]; e.ill = 0;
    wop = (f3 == 0) ? 11 + int'(alt) : (f3 == 1) ? 13 : 14 + int'(alt);
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.a = r1; e.b = r2;
        e.op = 4'(base[f3] + ((alt && (f3 == 0 || f3 == 5)) ? 1 : 0));
      end
      7'h13: begin
        e.a = r1;
        if (f3 == 1 || f3 == 5) begin
          e.b = {58'h0, ins[25:20]};
          ok = (ins[31:26] == 0) || (f3 == 5 && ins[31:26] == 6'h10);
          e.op = 4'(base[f3] + ((f3 == 5 && alt) ? 1 : 0));
        end else begin
          e.b = iimm; ok = 1; e.op = 4'(base[f3]);
        end
      end
      7'h3B: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 5) && (f7 == 0 || (f7 == 7'h20 && f3 != 1));
        e.a = r1; e.b = r2; e.op = 4'(wop);
      end
      7'h1B: begin
        e.a = r1;
        if (f3 == 0) begin
          ok = 1; e.b = iimm; e.op = 4'd11;
        end else if (f3 == 1 || f3 == 5) begin
          ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.b = {59'h0, ins[24:20]}; e.op = 4'(wop);
        end
      end
      7'h37: begin ok = 1; e.a = 0; e.b = uimm; e.op = 4'd10; end
      7'h17: begin ok = 1; e.a = p; e.b = uimm; e.op = 4'd0; end
      default: ok = 0;
    endcase
    if (!ok) begin e.a = 0; e.b = 0; e.op = 0; e.ill = 1; end
    return e;
  endfunction

  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("alu_a", alu_a, q[0].a);
      chk("alu_b", alu_b, q[0].b);
      chk("alu_op", 64'(alu_op), 64'(q[0].op));
      chk("rd", 64'(rd), 64'(q[0].rd));
      chk("illegal", 64'(illegal), 64'(q[0].ill));
    end
  endtask

  // Drive one cycle's inputs at the negedge, advance the model, then check at the next negedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] p,
                      input logic [63:0] r1, input logic [63:0] r2, input bit ordy, input bit fl);
    int sz;
    in_valid = v; instr = ins; pc = p; rs1 = r1; rs2 = r2; out_ready = ordy; flush = fl;
    sz = q.size();
    if (fl) q.delete();
    else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (v && sz < 2) q.push_back(ref_decode(ins, p, r1, r2));
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0] opcs [7] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h00};
    logic [6:0] opc = opcs[$urandom_range(0, 6)];
    if (opc == 7'h00) opc = 7'($urandom);
    r[6:0] = opc;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset alu_a", alu_a, 64'd0);
    chk("reset alu_b", alu_b, 64'd0);
    chk("reset op_rd", {55'd0, alu_op, rd}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    step(1, 32'hFFD10093, 0, 64'd5, 64'd99, 1, 0);
    chk("addi valid", 64'(out_valid), 64'd1);
    chk("addi op", 64'(alu_op), 64'd0);
    chk("addi a", alu_a, 64'd5);
    chk("addi b", alu_b, 64'hFFFFFFFFFFFFFFFD);
    chk("addi rd", 64'(rd), 64'd1);
    chk("addi ill", 64'(illegal), 64'd0);

    step(1, 32'h402081B3, 0, 64'd10, 64'd3, 1, 0);
    chk("sub op", 64'(alu_op), 64'd1);
    chk("sub a", alu_a, 64'd10);
    chk("sub b", alu_b, 64'd3);
    chk("sub rd", 64'(rd), 64'd3);

    step(1, 32'h800002B7, 64'h1000, 64'd7, 64'd8, 1, 0);
    chk("lui op", 64'(alu_op), 64'd10);
    chk("lui a", alu_a, 64'd0);
    chk("lui b", alu_b, 64'hFFFFFFFF80000000);

    step(1, 32'h4033D31B, 0, 64'h1234, 64'd0, 1, 0);
    chk("sraiw op", 64'(alu_op), 64'd15);
    chk("sraiw b", alu_b, 64'd3);

    step(1, 32'h0200109B, 0, 64'h55, 64'h66, 1, 0);
    chk("slliw32 ill", 64'(illegal), 64'd1);
    chk("slliw32 op", 64'(alu_op), 64'd0);
    chk("slliw32 a", alu_a, 64'd0);
    chk("slliw32 b", alu_b, 64'd0);
    chk("slliw32 rd", 64'(rd), 64'd1);

    step(0, 0, 0, 0, 0, 1, 0);
    chk("drain empty", 64'(out_valid), 64'd0);

    // Backpressure: I0 -> out, I1 -> skid, I2 held until space.
    step(1, 32'h00000513, 0, 1, 0, 0, 0);
    step(1, 32'h00000593, 0, 2, 0, 0, 0);
    chk("bp in_ready low", 64'(in_ready), 64'd0);
    step(1, 32'h00000613, 0, 3, 0, 0, 0);
    chk("bp hold rd", 64'(rd), 64'd10);
    chk("bp hold a", alu_a, 64'd1);
    step(1, 32'h00000613, 0, 3, 0, 1, 0);
    chk("bp second rd", 64'(rd), 64'd11);
    chk("bp ready back", 64'(in_ready), 64'd1);
    step(1, 32'h00000613, 0, 3, 0, 1, 0);
    chk("bp third rd", 64'(rd), 64'd12);
    chk("bp third valid", 64'(out_valid), 64'd1);
    step(0, 0, 0, 0, 0, 1, 0);

    // Flush with both entries full, input in flush cycle dropped.
    step(1, 32'h00000513, 0, 1, 0, 0, 0);
    step(1, 32'h00000593, 0, 2, 0, 0, 0);
    step(1, 32'h00000613, 0, 3, 0, 0, 1);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("flush nothing left", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset mid-stream with data buffered.
    step(1, 32'h00000513, 0, 1, 0, 0, 0);
    step(1, 32'h00000593, 0, 2, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk("async rst alu_a", alu_a, 64'd0);
    chk("async rst rd", 64'(rd), 64'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
    step(1, 32'hFFD10093, 0, 64'd5, 0, 1, 0);
    chk("post rst addi b", alu_b, 64'hFFFFFFFFFFFFFFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
